// File: rtl/aes_job_scheduler.sv
// aes_job_scheduler: round-robin arbiter sequencing enc/dec jobs on one AES core.
// Define AES_SCHED_TIMEOUT_EN to abort stalled jobs after TIMEOUT_CYCLES and expose timeout_err.
module aes_job_scheduler #(
  parameter int DATA_WIDTH = 128,
  parameter int TIMEOUT_CYCLES = 64,
  parameter bit FIRST_PRIO = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enc_req_valid,
  output logic                  enc_req_ready,
  input  logic [DATA_WIDTH-1:0] enc_req_data,
  input  logic [DATA_WIDTH-1:0] enc_req_key,
  output logic                  enc_rsp_valid,
  input  logic                  enc_rsp_ready,
  output logic [DATA_WIDTH-1:0] enc_rsp_data,
  input  logic                  dec_req_valid,
  output logic                  dec_req_ready,
  input  logic [DATA_WIDTH-1:0] dec_req_data,
  input  logic [DATA_WIDTH-1:0] dec_req_key,
  output logic                  dec_rsp_valid,
  input  logic                  dec_rsp_ready,
  output logic [DATA_WIDTH-1:0] dec_rsp_data,
  output logic                  core_start_encryption,
  output logic                  core_start_decryption,
  output logic [DATA_WIDTH-1:0] core_plaintext_encryption,
  output logic [DATA_WIDTH-1:0] core_cyphertext_decryption,
  output logic [DATA_WIDTH-1:0] core_key_encryption,
  input  logic [DATA_WIDTH-1:0] core_cyphertext_encryption,
  input  logic [DATA_WIDTH-1:0] core_plaintext_decryption,
  input  logic                  core_done_encryption,
  input  logic                  core_done_decyption,
  output logic                  busy
`ifdef AES_SCHED_TIMEOUT_EN
  ,
  output logic                  timeout_err
`endif
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic op_q, op_d, last_q, last_d;
  logic [DATA_WIDTH-1:0] pt_q, pt_d, ct_q, ct_d, key_q, key_d;
  logic [DATA_WIDTH-1:0] enc_rsp_q, enc_rsp_d, dec_rsp_q, dec_rsp_d, res;
  logic idle, grant_dec, accept, done, expire;
  // last_q = 1 means dec was served last, so contention favours enc
  assign idle = state_q == IDLE && !rst;
  assign grant_dec = dec_req_valid && (!enc_req_valid || !last_q);
  assign enc_req_ready = idle && enc_req_valid && !grant_dec;
  assign dec_req_ready = idle && grant_dec;
  assign accept = enc_req_ready || dec_req_ready;
  assign done = op_q ? core_done_decyption : core_done_encryption;
  assign res = done ? (op_q ? core_plaintext_decryption : core_cyphertext_encryption) : '0;
`ifdef AES_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic to_q;
  assign expire = state_q == WAIT && cnt_q == CW'(TIMEOUT_CYCLES - 1) && !done;
  assign cnt_d = state_q == WAIT ? cnt_q + 1'b1 : '0;
  assign timeout_err = to_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      to_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q <= expire;
    end
`else
  assign expire = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    last_d = last_q;
    pt_d = pt_q;
    ct_d = ct_q;
    key_d = key_q;
    enc_rsp_d = enc_rsp_q;
    dec_rsp_d = dec_rsp_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = ISSUE;
        op_d = grant_dec;
        last_d = grant_dec;
        pt_d = grant_dec ? pt_q : enc_req_data;
        ct_d = grant_dec ? dec_req_data : ct_q;
        key_d = grant_dec ? dec_req_key : enc_req_key;
      end
      ISSUE: state_d = WAIT;
      WAIT: if (done || expire) begin
        state_d = RESP;
        enc_rsp_d = op_q ? enc_rsp_q : res;
        dec_rsp_d = op_q ? res : dec_rsp_q;
      end
      RESP: state_d = (op_q ? dec_rsp_ready : enc_rsp_ready) ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      op_q <= 1'b0;
      last_q <= !FIRST_PRIO;
      pt_q <= '0;
      ct_q <= '0;
      key_q <= '0;
      enc_rsp_q <= '0;
      dec_rsp_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      last_q <= last_d;
      pt_q <= pt_d;
      ct_q <= ct_d;
      key_q <= key_d;
      enc_rsp_q <= enc_rsp_d;
      dec_rsp_q <= dec_rsp_d;
    end
  assign core_start_encryption = state_q == ISSUE && !op_q;
  assign core_start_decryption = state_q == ISSUE && op_q;
  assign enc_rsp_valid = state_q == RESP && !op_q;
  assign dec_rsp_valid = state_q == RESP && op_q;
  assign busy = state_q != IDLE;
  assign core_plaintext_encryption = pt_q;
  assign core_cyphertext_decryption = ct_q;
  assign core_key_encryption = key_q;
  assign enc_rsp_data = enc_rsp_q;
  assign dec_rsp_data = dec_rsp_q;
endmodule
